// File: rtl/burst_mem_responder.sv
// burst_mem_responder: target side of the burst user interface, serving burst
// writes and reads from an on-chip block RAM in place of a DDR controller.
// Every output is registered. The BRAM keeps its contents across reset.
module burst_mem_responder #(
  parameter int MEM_DATA_BITS  = 32,
  parameter int ADDR_BITS      = 23,
  parameter int BUSRT_BITS     = 10,
  parameter int MEM_DEPTH_BITS = 12
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     rd_burst_req,
  input  logic                     wr_burst_req,
  input  logic [BUSRT_BITS-1:0]    rd_burst_len,
  input  logic [BUSRT_BITS-1:0]    wr_burst_len,
  input  logic [ADDR_BITS-1:0]     rd_burst_addr,
  input  logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     stall,
  output logic                     rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] rd_burst_data,
  output logic                     wr_burst_data_req,
  output logic                     rd_burst_finish,
  output logic                     wr_burst_finish,
  output logic                     busy
);

  localparam int DEPTH = 1 << MEM_DEPTH_BITS;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_BEATS = 3'd1;
  localparam logic [2:0] S_WR_TAIL  = 3'd2;
  localparam logic [2:0] S_RD_BEATS = 3'd3;
  localparam logic [2:0] S_RD_TAIL  = 3'd4;
  localparam logic [2:0] S_FINISH   = 3'd5;

  logic [2:0]                state_q, state_d;
  logic [MEM_DEPTH_BITS-1:0] base_q, base_d;
  logic [BUSRT_BITS-1:0]     len_q, len_d;
  logic [BUSRT_BITS-1:0]     cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic                      wr_fin_q, wr_fin_d;
  logic                      rd_fin_q, rd_fin_d;
  logic                      wr_issue, rd_issue;

  // Write pipeline: request -> (initiator supplies data next cycle) -> BRAM write.
  logic                      wr_req_q;
  logic [MEM_DEPTH_BITS-1:0] wr_req_addr_q;
  logic                      wr_en_q;
  logic [MEM_DEPTH_BITS-1:0] wr_addr_q;

  // Read pipeline: BRAM read register -> reset-able output register.
  logic                      rd_issue_q;
  logic                      rd_valid_q;
  logic [MEM_DATA_BITS-1:0]  rd_data_q;
  logic [MEM_DATA_BITS-1:0]  ram_dout_q;

  logic [MEM_DATA_BITS-1:0]  mem_q [0:DEPTH-1];

  // Word address of the current beat; wraps within the BRAM depth.
  logic [MEM_DEPTH_BITS-1:0] beat_addr;
  assign beat_addr = base_q + MEM_DEPTH_BITS'(cnt_q);

  // Upper address bits select nothing in this memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_burst_addr[ADDR_BITS-1:MEM_DEPTH_BITS],
                              rd_burst_addr[ADDR_BITS-1:MEM_DEPTH_BITS]};

  // Next-state logic: acceptance in IDLE, beat issue while not stalled, tail, finish.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    wr_fin_d = 1'b0;
    rd_fin_d = 1'b0;
    wr_issue = 1'b0;
    rd_issue = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (wr_burst_req) begin
          state_d = S_WR_BEATS;
          base_d  = wr_burst_addr[MEM_DEPTH_BITS-1:0];
          len_d   = wr_burst_len;
          busy_d  = 1'b1;
        end else if (rd_burst_req) begin
          state_d = S_RD_BEATS;
          base_d  = rd_burst_addr[MEM_DEPTH_BITS-1:0];
          len_d   = rd_burst_len;
          busy_d  = 1'b1;
        end
      end
      S_WR_BEATS: begin
        if (cnt_q == len_q) begin
          state_d = S_WR_TAIL;
        end else if (!stall) begin
          wr_issue = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      // One cycle for the last beat to arrive and be written.
      S_WR_TAIL: begin
        state_d  = S_FINISH;
        wr_fin_d = 1'b1;
      end
      S_RD_BEATS: begin
        if (cnt_q == len_q) begin
          state_d = S_RD_TAIL;
        end else if (!stall) begin
          rd_issue = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      // One cycle for the last read beat to leave the output register.
      S_RD_TAIL: begin
        state_d  = S_FINISH;
        rd_fin_d = 1'b1;
      end
      // Finish pulse is visible here; IDLE samples requests only after the
      // initiator has had a cycle to react to it.
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset abandons any burst in progress.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      wr_fin_q      <= 1'b0;
      rd_fin_q      <= 1'b0;
      wr_req_q      <= 1'b0;
      wr_req_addr_q <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      rd_issue_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      wr_fin_q   <= wr_fin_d;
      rd_fin_q   <= rd_fin_d;
      wr_req_q   <= wr_issue;
      if (wr_issue) begin
        wr_req_addr_q <= beat_addr;
      end
      wr_en_q    <= wr_req_q;
      wr_addr_q  <= wr_req_addr_q;
      rd_issue_q <= rd_issue;
      rd_valid_q <= rd_issue_q;
      if (rd_issue_q) begin
        rd_data_q <= ram_dout_q;
      end
    end
  end

  // Block RAM: one write port fed by the beat pipeline, one registered read port.
  always_ff @(posedge mem_clk) begin
    if (wr_en_q) begin
      mem_q[wr_addr_q] <= wr_burst_data;
    end
    if (rd_issue) begin
      ram_dout_q <= mem_q[beat_addr];
    end
  end

  assign wr_burst_data_req   = wr_req_q;
  assign wr_burst_finish     = wr_fin_q;
  assign rd_burst_finish     = rd_fin_q;
  assign rd_burst_data_valid = rd_valid_q;
  assign rd_burst_data       = rd_data_q;
  assign busy                = busy_q;

endmodule
